// File: rtl/mul32_pp_driver.sv
// mul32_pp_driver: multi-cycle 32x32 multiplier driving a CSA tree and resolving its sum/carry output.
// Optional MUL_BYPASS_ZERO_EN: zero operands skip the tree and complete directly with product 0.
module mul32_pp_driver #(
    parameter int N        = 32,
    parameter int ADD_LO_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       a,
    input  logic [N-1:0]       b,
    input  logic               is_signed,
    output logic [2*N*N-1:0]   pp,
    input  logic [2*N-1:0]     s_in,
    input  logic [2*N-1:0]     c_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*N-1:0]     product
);
    localparam int W  = 2 * N;
    localparam int HW = W - ADD_LO_W;
    typedef enum logic [2:0] {IDLE, TREE, ADD_LO, ADD_HI, DONE} state_t;
    state_t              state;
    logic [N-1:0]        ar, br;
    logic                sr, cy, bypass;
    logic [W-1:0]        s_r, c_r, ae;
    logic [ADD_LO_W:0]   lo_sum;
    logic [HW-1:0]       hi_sum;
    assign ae     = sr ? {{N{ar[N-1]}}, ar} : {{N{1'b0}}, ar};
    assign lo_sum = {1'b0, s_r[ADD_LO_W-1:0]} + {1'b0, c_r[ADD_LO_W-1:0]};
    assign hi_sum = s_r[W-1:ADD_LO_W] + c_r[W-1:ADD_LO_W] + {{(HW-1){1'b0}}, cy};
`ifdef MUL_BYPASS_ZERO_EN
    assign bypass = (a == '0) || (b == '0);
`else
    assign bypass = 1'b0;
`endif
    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_row
            logic [W-1:0] sh;
            assign sh = ae << i;
            // the sign-bit row of a signed multiplier carries negative weight
            assign pp[W*i +: W] = (state == IDLE || !br[i]) ? '0 : (sr && i == N-1) ? -sh : sh;
        end
    endgenerate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            ar        <= '0;
            br        <= '0;
            sr        <= 1'b0;
            s_r       <= '0;
            c_r       <= '0;
            cy        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    in_ready  <= 1'b0;
                    ar        <= bypass ? '0 : a;
                    br        <= bypass ? '0 : b;
                    sr        <= bypass ? 1'b0 : is_signed;
                    out_valid <= bypass;
                    if (bypass) product <= '0;
                    state     <= bypass ? DONE : TREE;
                end
                TREE: begin
                    s_r   <= s_in;
                    c_r   <= c_in;
                    state <= ADD_LO;
                end
                ADD_LO: begin
                    product[ADD_LO_W-1:0] <= lo_sum[ADD_LO_W-1:0];
                    cy                    <= lo_sum[ADD_LO_W];
                    state                 <= ADD_HI;
                end
                ADD_HI: begin
                    product[W-1:ADD_LO_W] <= hi_sum;
                    out_valid             <= 1'b1;
                    state                 <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul32_pp_driver.sv
// tb_mul32_pp_driver: directed checks of mul32_pp_driver with a behavioural stand-in for the CSA tree.
module tb_mul32_pp_driver;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready, is_signed = 1'b0;
    logic [31:0]   a = '0, b = '0;
    logic [2047:0] pp;
    logic [63:0]   s_in, c_in, product;
    logic          out_valid, out_ready = 1'b1;
    int            errors = 0, checks = 0;

    mul32_pp_driver dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .pp(pp), .s_in(s_in), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    always #5 clk = ~clk;

    // row 0 goes on the sum vector and the rest on the carry vector so the low add produces real carries
    always_comb begin
        s_in = pp[63:0];
        c_in = '0;
        for (int i = 1; i < 32; i++) c_in += pp[64*i +: 64];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // accept one operation, measure cycles until out_valid, check product, then complete the handshake
    task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                       input logic [63:0] exp, input int lat);
        int n;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a = ta; b = tb; is_signed = ts; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_product"}, product, exp);
        @(posedge clk); #1;
        chk({tag, "_done_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_done_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int zlat;
`ifdef MUL_BYPASS_ZERO_EN
        zlat = 1;
`else
        zlat = 4;
`endif
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_pp", 64'(pp != '0), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("u3x5", 32'd3, 32'd5, 1'b0, 64'h000000000000000F, 4);
        chk("idle_pp", 64'(pp != '0), 64'd0);
        run("uffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 4);
        run("sm1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, 4);
        run("s80x2", 32'h80000000, 32'd2, 1'b1, 64'hFFFFFFFF00000000, 4);
        run("s3xm2", 32'd3, 32'hFFFFFFFE, 1'b1, 64'hFFFFFFFFFFFFFFFA, 4);

        // backpressure: a competing request during the hold must not be taken
        a = 32'd6; b = 32'd7; is_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        a = 32'd2; b = 32'd2;
        for (int k = 0; k < 10 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid_rise", 64'(out_valid), 64'd1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_product", product, 64'd42);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 64'(out_valid), 64'd0);
        run("bp_next", 32'd2, 32'd2, 1'b0, 64'd4, 4);

        // reset during ADD_LO
        a = 32'd100; b = 32'd100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_product", product, 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        run("u7x9", 32'd7, 32'd9, 1'b0, 64'd63, 4);

        run("zero", 32'd0, 32'h12345678, 1'b0, 64'd0, zlat);
        run("after_zero", 32'd11, 32'd13, 1'b0, 64'd143, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
